// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with valid/ready handshake, 2-entry skid and flush.
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int REG_W = 4,
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter logic [4:0] OP_ALU = 5'h00,
  parameter logic [4:0] OP_CMP = 5'h01,
  parameter logic [4:0] OP_JMP = 5'h02,
  parameter logic [4:0] OP_LD = 5'h03,
  parameter logic [4:0] OP_STR = 5'h04,
  parameter logic [4:0] OP_CALL = 5'h05,
  parameter logic [4:0] OP_RET = 5'h06,
  localparam int IMM_W = INSTR_W - 6 - 2 * REG_W,
  localparam int MD_W = INSTR_W - 6 - REG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rt,
  output logic [DATA_W-1:0]  out_imm,
  output logic [MD_W-1:0]    out_md,
  output logic [8:0]         out_flags
);
  if (IMM_W < 1 || DATA_W < IMM_W) begin : g_width_check
    $error("decode_stage: need IMM_W >= 1 and DATA_W >= IMM_W");
  end
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [5:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] imm;
    logic [MD_W-1:0]   md;
    logic [8:0]        flags;
  } dec_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q;
  dec_t dec_d, out_q, skid_q;
  logic in_ready_q, out_valid_q;
  logic [4:0] maj;
  logic [6:0] cls;
  logic in_x, out_x;
  always_comb begin
    maj = in_instr[INSTR_W-1 -: 5];
    cls = {maj == OP_RET, maj == OP_CALL, maj == OP_STR, maj == OP_LD,
           maj == OP_JMP, maj == OP_CMP, maj == OP_ALU};
    dec_d.pc = in_pc;
    dec_d.opcode = in_instr[INSTR_W-1 -: 6];
    dec_d.rd = in_instr[INSTR_W-7 -: REG_W];
    dec_d.rs = in_instr[INSTR_W-7-REG_W -: REG_W];
    dec_d.rt = in_instr[INSTR_W-7-2*REG_W -: REG_W];
    dec_d.imm = DATA_W'($signed(in_instr[IMM_W-1:0]));
    dec_d.md = in_instr[MD_W-1:0];
    dec_d.flags = {~|cls, in_instr[INSTR_W-6], cls};
  end
  assign in_x = in_valid && in_ready_q;
  assign out_x = out_valid_q && out_ready;
  // in_ready_q always tracks (next state != TWO), so upstream never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (in_x) begin
          out_q <= dec_d;
          out_valid_q <= 1'b1;
          state_q <= ONE;
        end
        ONE: if (in_x && out_x) begin
          out_q <= dec_d;
        end else if (in_x) begin
          skid_q <= dec_d;
          in_ready_q <= 1'b0;
          state_q <= TWO;
        end else if (out_x) begin
          out_valid_q <= 1'b0;
          state_q <= EMPTY;
        end
        TWO: if (out_x) begin
          out_q <= skid_q;
          in_ready_q <= 1'b1;
          state_q <= ONE;
        end
        default: begin
          state_q <= EMPTY;
          in_ready_q <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc = out_q.pc;
  assign out_opcode = out_q.opcode;
  assign out_rd = out_q.rd;
  assign out_rs = out_q.rs;
  assign out_rt = out_q.rt;
  assign out_imm = out_q.imm;
  assign out_md = out_q.md;
  assign out_flags = out_q.flags;
endmodule
